// File: rtl/order_matcher.sv
// Single-level order matcher: one resting bid, one resting ask, crossed on a one-cycle CHECK.
// Optional statistics outputs (trade_count, total_volume) are built when ORDER_MATCHER_STATS_EN is defined.
module order_matcher #(
  parameter int PRICE_W = 8,
  parameter int QTY_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               buy_valid,
  output logic               buy_ready,
  input  logic [PRICE_W-1:0] buy_price,
  input  logic [QTY_W-1:0]   buy_qty,
  input  logic               sell_valid,
  output logic               sell_ready,
  input  logic [PRICE_W-1:0] sell_price,
  input  logic [QTY_W-1:0]   sell_qty,
  input  logic               cancel_bid,
  input  logic               cancel_ask,
  output logic               match_signal,
  output logic [PRICE_W-1:0] match_buy_price,
  output logic [PRICE_W-1:0] match_sell_price,
  output logic [QTY_W-1:0]   match_qty,
  output logic               bid_valid,
  output logic               ask_valid
`ifdef ORDER_MATCHER_STATS_EN
  ,
  output logic [15:0]        trade_count,
  output logic [15:0]        total_volume
`endif
);

  typedef enum logic [1:0] {IDLE, CHECK, MATCH} state_e;

  state_e             state_q, state_d;
  logic [PRICE_W-1:0] bid_price_q, ask_price_q;
  logic [QTY_W-1:0]   bid_qty_q, ask_qty_q;
  logic               bid_valid_q, ask_valid_q;
  logic [PRICE_W-1:0] mbuy_q, msell_q;
  logic [QTY_W-1:0]   mqty_q;

  logic               buy_rdy, sell_rdy;
  logic               buy_load, sell_load;
  logic               cxl_bid, cxl_ask;
  logic               crossed, trade;
  logic [QTY_W-1:0]   trade_qty;

  // Ready only in IDLE with an empty slot, so a cancel on an occupied slot
  // automatically blocks the same-cycle order on that side.
  assign buy_rdy   = (state_q == IDLE) && !bid_valid_q;
  assign sell_rdy  = (state_q == IDLE) && !ask_valid_q;
  assign buy_load  = buy_valid && buy_rdy && (buy_qty != '0);
  assign sell_load = sell_valid && sell_rdy && (sell_qty != '0);
  assign cxl_bid   = cancel_bid && (state_q == IDLE) && bid_valid_q;
  assign cxl_ask   = cancel_ask && (state_q == IDLE) && ask_valid_q;

  assign crossed   = bid_valid_q && ask_valid_q && (bid_price_q >= ask_price_q);
  assign trade     = (state_q == CHECK) && crossed;
  assign trade_qty = (bid_qty_q < ask_qty_q) ? bid_qty_q : ask_qty_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (buy_load || sell_load) state_d = CHECK;
      CHECK:   state_d = crossed ? MATCH : IDLE;
      MATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    buy_ready    = buy_rdy;
    sell_ready   = sell_rdy;
    match_signal = (state_q == MATCH);
  end

  // Resting book. Loads and cancels only happen in IDLE, trades only in CHECK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bid_price_q <= '0;
      bid_qty_q   <= '0;
      bid_valid_q <= 1'b0;
      ask_price_q <= '0;
      ask_qty_q   <= '0;
      ask_valid_q <= 1'b0;
    end else begin
      if (buy_load) begin
        bid_price_q <= buy_price;
        bid_qty_q   <= buy_qty;
        bid_valid_q <= 1'b1;
      end else if (cxl_bid) begin
        bid_valid_q <= 1'b0;
      end else if (trade) begin
        bid_qty_q <= bid_qty_q - trade_qty;
        if (bid_qty_q == trade_qty) bid_valid_q <= 1'b0;
      end

      if (sell_load) begin
        ask_price_q <= sell_price;
        ask_qty_q   <= sell_qty;
        ask_valid_q <= 1'b1;
      end else if (cxl_ask) begin
        ask_valid_q <= 1'b0;
      end else if (trade) begin
        ask_qty_q <= ask_qty_q - trade_qty;
        if (ask_qty_q == trade_qty) ask_valid_q <= 1'b0;
      end
    end
  end

  // Last-trade report, held until the next trade
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mbuy_q  <= '0;
      msell_q <= '0;
      mqty_q  <= '0;
    end else if (trade) begin
      mbuy_q  <= bid_price_q;
      msell_q <= ask_price_q;
      mqty_q  <= trade_qty;
    end
  end

  assign match_buy_price  = mbuy_q;
  assign match_sell_price = msell_q;
  assign match_qty        = mqty_q;
  assign bid_valid        = bid_valid_q;
  assign ask_valid        = ask_valid_q;

`ifdef ORDER_MATCHER_STATS_EN
  logic [15:0] trade_count_q, total_volume_q;
  logic [31:0] vol_sum;

  // Count wraps; volume saturates so a long run never reports a small total.
  assign vol_sum = 32'(total_volume_q) + 32'(trade_qty);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trade_count_q  <= '0;
      total_volume_q <= '0;
    end else if (trade) begin
      trade_count_q  <= trade_count_q + 16'd1;
      total_volume_q <= (vol_sum > 32'h0000_FFFF) ? 16'hFFFF : vol_sum[15:0];
    end
  end

  assign trade_count  = trade_count_q;
  assign total_volume = total_volume_q;
`endif

endmodule

// File: tb/tb_order_matcher.sv
// Self-checking bench for order_matcher: directed vector table, hand-written corner
// sequences, and random transactions against a transaction-level book model.
module tb_order_matcher;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       buy_valid, sell_valid, cancel_bid, cancel_ask;
  logic       buy_ready, sell_ready;
  logic [7:0] buy_price, buy_qty, sell_price, sell_qty;
  logic       match_signal, bid_valid, ask_valid;
  logic [7:0] match_buy_price, match_sell_price, match_qty;
`ifdef ORDER_MATCHER_STATS_EN
  logic [15:0] trade_count, total_volume;
`endif

  int total = 0;
  int bad   = 0;

  order_matcher #(.PRICE_W(8), .QTY_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .buy_valid(buy_valid), .buy_ready(buy_ready), .buy_price(buy_price), .buy_qty(buy_qty),
    .sell_valid(sell_valid), .sell_ready(sell_ready), .sell_price(sell_price), .sell_qty(sell_qty),
    .cancel_bid(cancel_bid), .cancel_ask(cancel_ask),
    .match_signal(match_signal), .match_buy_price(match_buy_price),
    .match_sell_price(match_sell_price), .match_qty(match_qty),
    .bid_valid(bid_valid), .ask_valid(ask_valid)
`ifdef ORDER_MATCHER_STATS_EN
    , .trade_count(trade_count), .total_volume(total_volume)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    buy_valid = 0; sell_valid = 0; cancel_bid = 0; cancel_ask = 0;
    buy_price = 0; buy_qty = 0; sell_price = 0; sell_qty = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
  endtask

  // One transaction from IDLE: drive for one edge, then watch three cycles.
  // 'at' is the sample index of the pulse (1 = between edges N+1 and N+2).
  task automatic submit(input bit db, input logic [7:0] bp, input logic [7:0] bq,
                        input bit ds, input logic [7:0] sp, input logic [7:0] sq,
                        input bit cb, input bit ca,
                        output int pulses, output int at, output bit rb, output bit rs);
    buy_valid = db; buy_price = bp; buy_qty = bq;
    sell_valid = ds; sell_price = sp; sell_qty = sq;
    cancel_bid = cb; cancel_ask = ca;
    rb = buy_ready; rs = sell_ready;
    tick();
    clear_inputs();
    pulses = 0; at = -1;
    for (int i = 0; i < 3; i++) begin
      if (match_signal) begin
        pulses++;
        if (at < 0) at = i;
      end
      tick();
    end
  endtask

  typedef struct {
    logic [7:0] bp, bq, sp, sq;
    bit         same;
    int         pulses;
    logic [7:0] mq, mb, ms;
    bit         bv, av;
  } vec_t;

  vec_t vecs[8];

  // Transaction-level book model
  logic [7:0] m_bp, m_bq, m_sp, m_sq, m_mb, m_ms, m_mq;
  bit         m_bv, m_av;
  int         m_tc, m_tv;

  function automatic int apply_model(bit db, logic [7:0] bp, logic [7:0] bq,
                                     bit ds, logic [7:0] sp, logic [7:0] sq,
                                     bit cb, bit ca);
    bit acc_b, acc_s, ld;
    logic [7:0] q;
    acc_b = db && !m_bv;
    acc_s = ds && !m_av;
    if (cb && m_bv) m_bv = 0;
    if (ca && m_av) m_av = 0;
    ld = 0;
    if (acc_b && bq != 0) begin m_bp = bp; m_bq = bq; m_bv = 1; ld = 1; end
    if (acc_s && sq != 0) begin m_sp = sp; m_sq = sq; m_av = 1; ld = 1; end
    if (ld && m_bv && m_av && m_bp >= m_sp) begin
      q = (m_bq < m_sq) ? m_bq : m_sq;
      m_mb = m_bp; m_ms = m_sp; m_mq = q;
      m_bq = m_bq - q; m_sq = m_sq - q;
      if (m_bq == 0) m_bv = 0;
      if (m_sq == 0) m_av = 0;
      m_tc = (m_tc + 1) % 65536;
      m_tv = (m_tv + int'(q) > 65535) ? 65535 : m_tv + int'(q);
      return 1;
    end
    return 0;
  endfunction

  initial begin
    int p, p2, at;
    bit rb, rs;
    vecs[0] = '{8'd80,  8'd10, 8'd70,  8'd4, 1'b0, 1, 8'd4, 8'd80,  8'd70,  1'b1, 1'b0};
    vecs[1] = '{8'd60,  8'd5,  8'd72,  8'd5, 1'b0, 0, 8'd0, 8'd0,   8'd0,   1'b1, 1'b1};
    vecs[2] = '{8'd50,  8'd3,  8'd50,  8'd3, 1'b1, 1, 8'd3, 8'd50,  8'd50,  1'b0, 1'b0};
    vecs[3] = '{8'd90,  8'd0,  8'd10,  8'd0, 1'b0, 0, 8'd0, 8'd0,   8'd0,   1'b0, 1'b0};
    vecs[4] = '{8'd100, 8'd2,  8'd100, 8'd7, 1'b1, 1, 8'd2, 8'd100, 8'd100, 1'b0, 1'b1};
    vecs[5] = '{8'd255, 8'd1,  8'd0,   8'd1, 1'b0, 1, 8'd1, 8'd255, 8'd0,   1'b0, 1'b0};
    vecs[6] = '{8'd0,   8'd5,  8'd1,   8'd5, 1'b0, 0, 8'd0, 8'd0,   8'd0,   1'b1, 1'b1};
    vecs[7] = '{8'd30,  8'd6,  8'd20,  8'd6, 1'b0, 1, 8'd6, 8'd30,  8'd20,  1'b0, 1'b0};

    // Reset state
    clear_inputs();
    reset_n = 0;
    #12;
    chk("rst_match_signal", match_signal, 0);
    chk("rst_bid_valid", bid_valid, 0);
    chk("rst_ask_valid", ask_valid, 0);
    chk("rst_match_qty", match_qty, 0);
    chk("rst_match_bp", match_buy_price, 0);
    chk("rst_match_sp", match_sell_price, 0);
    @(negedge clk);
    reset_n = 1;
    #1;
    chk("rel_buy_ready", buy_ready, 1);
    chk("rel_sell_ready", sell_ready, 1);
    @(negedge clk);

    // Directed vector table, each from a fresh reset
    foreach (vecs[i]) begin
      do_reset();
      if (vecs[i].same) begin
        submit(1, vecs[i].bp, vecs[i].bq, 1, vecs[i].sp, vecs[i].sq, 0, 0, p, at, rb, rs);
      end else begin
        submit(1, vecs[i].bp, vecs[i].bq, 0, 0, 0, 0, 0, p2, at, rb, rs);
        submit(0, 0, 0, 1, vecs[i].sp, vecs[i].sq, 0, 0, p, at, rb, rs);
        p += p2;
      end
      chk($sformatf("vec%0d_pulses", i), p, vecs[i].pulses);
      chk($sformatf("vec%0d_latency", i), at, vecs[i].pulses != 0 ? 1 : -1);
      chk($sformatf("vec%0d_mqty", i), match_qty, vecs[i].mq);
      chk($sformatf("vec%0d_mbp", i), match_buy_price, vecs[i].mb);
      chk($sformatf("vec%0d_msp", i), match_sell_price, vecs[i].ms);
      chk($sformatf("vec%0d_bidv", i), bid_valid, vecs[i].bv);
      chk($sformatf("vec%0d_askv", i), ask_valid, vecs[i].av);
    end

    // Residual bid of 6 fully consumed by a second sell; report held afterwards
    do_reset();
    submit(1, 80, 10, 0, 0, 0, 0, 0, p, at, rb, rs);
    submit(0, 0, 0, 1, 70, 4, 0, 0, p, at, rb, rs);
    submit(0, 0, 0, 1, 70, 9, 0, 0, p, at, rb, rs);
    chk("resid_pulse", p, 1);
    chk("resid_qty", match_qty, 6);
    chk("resid_bidv", bid_valid, 0);
    chk("resid_askv", ask_valid, 1);
    repeat (4) tick();
    chk("hold_qty", match_qty, 6);
    chk("hold_bp", match_buy_price, 80);

    // Cancel ask in IDLE; cancel on occupied blocks order; cancel on empty lets it in
    do_reset();
    submit(1, 60, 5, 0, 0, 0, 0, 0, p, at, rb, rs);
    submit(0, 0, 0, 1, 72, 5, 0, 0, p, at, rb, rs);
    chk("nocross_pulse", p, 0);
    cancel_ask = 1; tick(); cancel_ask = 0;
    chk("cxl_askv", ask_valid, 0);
    chk("cxl_sell_ready", sell_ready, 1);
    submit(1, 90, 3, 0, 0, 0, 1, 0, p, at, rb, rs);
    chk("cxl_blk_ready", rb, 0);
    chk("cxl_blk_bidv", bid_valid, 0);
    submit(0, 0, 0, 1, 70, 2, 0, 1, p, at, rb, rs);
    chk("cxl_empty_askv", ask_valid, 1);
    chk("cxl_empty_pulse", p, 0);

    // Zero-qty order dropped without CHECK; held order against occupied bid refused
    do_reset();
    buy_valid = 1; buy_price = 90; buy_qty = 0;
    tick(); clear_inputs();
    chk("zero_bidv", bid_valid, 0);
    chk("zero_no_check", buy_ready, 1);
    submit(1, 40, 2, 0, 0, 0, 0, 0, p, at, rb, rs);
    buy_valid = 1; buy_price = 99; buy_qty = 9;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("held_ready%0d", i), buy_ready, 0);
      tick();
    end
    clear_inputs();
    submit(0, 0, 0, 1, 99, 9, 0, 0, p, at, rb, rs);
    chk("held_not_taken", p, 0);

    // Cancel during CHECK is ignored and not remembered
    do_reset();
    submit(1, 60, 5, 0, 0, 0, 0, 0, p, at, rb, rs);
    sell_valid = 1; sell_price = 70; sell_qty = 5;
    tick(); clear_inputs();
    cancel_bid = 1; tick(); cancel_bid = 0;
    tick();
    chk("cxl_check_bidv", bid_valid, 1);

    // Reset during CHECK of a crossing pair aborts the trade
    do_reset();
    submit(1, 82, 5, 0, 0, 0, 0, 0, p, at, rb, rs);
    sell_valid = 1; sell_price = 78; sell_qty = 5;
    tick(); clear_inputs();
    reset_n = 0;
    #1;
    chk("abort_bidv", bid_valid, 0);
    chk("abort_askv", ask_valid, 0);
    tick();
    reset_n = 1;
    p = 0;
    for (int i = 0; i < 4; i++) begin
      if (match_signal) p++;
      tick();
    end
    chk("abort_pulses", p, 0);
    chk("abort_mqty", match_qty, 0);
    chk("abort_mbp", match_buy_price, 0);
    chk("abort_msp", match_sell_price, 0);

`ifdef ORDER_MATCHER_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      submit(1, 100, 200, 1, 100, 200, 0, 0, p, at, rb, rs);
    end
    chk("stats_count", trade_count, 3);
    chk("stats_volume", total_volume, 600);
    for (int i = 0; i < 260; i++) begin
      submit(1, 100, 255, 1, 100, 255, 0, 0, p, at, rb, rs);
    end
    chk("stats_count_big", trade_count, 263);
    chk("stats_volume_sat", total_volume, 65535);
`endif

    // Random transactions against the book model
    do_reset();
    m_bp = 0; m_bq = 0; m_sp = 0; m_sq = 0; m_mb = 0; m_ms = 0; m_mq = 0;
    m_bv = 0; m_av = 0; m_tc = 0; m_tv = 0;
    for (int n = 0; n < 300; n++) begin
      bit db, ds, cb, ca, eb, es;
      int ep;
      logic [7:0] bp, bq, sp, sq;
      db = ($urandom_range(0, 2) != 0);
      ds = ($urandom_range(0, 2) != 0);
      cb = ($urandom_range(0, 5) == 0);
      ca = ($urandom_range(0, 5) == 0);
      bp = 8'($urandom_range(40, 60)); bq = 8'($urandom_range(0, 6));
      sp = 8'($urandom_range(40, 60)); sq = 8'($urandom_range(0, 6));
      eb = !m_bv; es = !m_av;
      ep = apply_model(db, bp, bq, ds, sp, sq, cb, ca);
      submit(db, bp, bq, ds, sp, sq, cb, ca, p, at, rb, rs);
      chk($sformatf("rnd%0d_brdy", n), rb, eb);
      chk($sformatf("rnd%0d_srdy", n), rs, es);
      chk($sformatf("rnd%0d_pulses", n), p, ep);
      if (ep != 0) chk($sformatf("rnd%0d_latency", n), at, 1);
      chk($sformatf("rnd%0d_bidv", n), bid_valid, m_bv);
      chk($sformatf("rnd%0d_askv", n), ask_valid, m_av);
      chk($sformatf("rnd%0d_mqty", n), match_qty, m_mq);
      chk($sformatf("rnd%0d_mbp", n), match_buy_price, m_mb);
      chk($sformatf("rnd%0d_msp", n), match_sell_price, m_ms);
`ifdef ORDER_MATCHER_STATS_EN
      chk($sformatf("rnd%0d_tc", n), trade_count, m_tc);
      chk($sformatf("rnd%0d_tv", n), total_volume, m_tv);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/order_matcher.md
ORDER_MATCHER -- requirements
Module: order_matcher

Interface
REQ-001 Parameter PRICE_W, default 8, SHALL set price width of all price ports and slots.
REQ-002 Parameter QTY_W, default 8, SHALL set quantity width of all quantity ports and slots.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 buy_valid / buy_ready  input / output  1 / 1  SHALL form the buy-order handshake; transfer when both high at a rising edge.
REQ-006 buy_price / buy_qty  input  PRICE_W / QTY_W  SHALL carry the offered buy order.
REQ-007 sell_valid / sell_ready / sell_price / sell_qty  same directions and widths as buy side  SHALL form the sell-order handshake.
REQ-008 cancel_bid / cancel_ask  input  1 each  SHALL request clearing of the resting bid / ask.
REQ-009 match_signal  output  1  SHALL pulse high for one cycle per trade.
REQ-010 match_buy_price / match_sell_price  output  PRICE_W  SHALL hold the bid and ask prices of the most recent trade.
REQ-011 match_qty  output  QTY_W  SHALL hold the quantity of the most recent trade.
REQ-012 bid_valid / ask_valid  output  1 each  SHALL indicate an occupied resting slot.

Function
REQ-013 Block SHALL hold one resting bid slot and one resting ask slot, each {price, qty, valid}.
REQ-014 FSM states SHALL be IDLE, CHECK, MATCH.
REQ-015 buy_ready SHALL equal (state==IDLE && !bid_valid); sell_ready SHALL equal (state==IDLE && !ask_valid).
REQ-016 Accepted order with qty>0 SHALL load its slot and set valid at that edge; FSM SHALL go IDLE->CHECK at the same edge.
REQ-017 Accepted order with qty==0 SHALL be consumed and dropped, slot unchanged, FSM unchanged.
REQ-018 Buy and sell acceptance in the same cycle SHALL both load; single IDLE->CHECK transition.
REQ-019 CHECK, one cycle: if bid_valid && ask_valid && bid_price>=ask_price (unsigned), SHALL go to MATCH; else SHALL return to IDLE.
REQ-020 On CHECK->MATCH edge: match_qty<=min(bid_qty,ask_qty); match_buy_price<=bid_price; match_sell_price<=ask_price; both slot qtys SHALL decrease by match_qty; a slot reaching 0 SHALL clear valid.
REQ-021 match_signal SHALL be high exactly during the MATCH cycle; MATCH SHALL always go to IDLE next edge.
REQ-022 Latency: order accepted at edge N that crosses SHALL give match_signal high between edges N+1 and N+2.
REQ-023 Residual qty SHALL rest in its slot; no rematch until a new order is accepted.
REQ-024 Match output prices/qty SHALL hold their values until the next trade.
REQ-025 cancel_bid/cancel_ask SHALL act only in IDLE, clearing valid of an occupied slot; ignored in CHECK/MATCH and not remembered.
REQ-026 Cancel on an occupied slot SHALL take precedence; the same-cycle order on that side is not accepted (ready low). Cancel on an empty slot SHALL be ignored and the order accepted.

Reset
REQ-027 reset_n low SHALL asynchronously force state=IDLE, both slots invalid with price/qty 0, match_signal=0, match prices/qty=0, stats counters=0.
REQ-028 Reset asserted in CHECK or MATCH SHALL abort the trade; no match_signal after release.
REQ-029 After release, buy_ready and sell_ready SHALL be 1 in the first cycle.

Configuration
REQ-030 With ORDER_MATCHER_STATS_EN defined, outputs trade_count[15:0] (+1 per MATCH, wraps 0xFFFF->0) and total_volume[15:0] (+match_qty per MATCH, saturates at 0xFFFF) SHALL exist.
REQ-031 Without ORDER_MATCHER_STATS_EN, those ports and their registers SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset release, buy 80x10, then sell 70x4 -> one match_signal pulse, match_buy_price=80, match_sell_price=70, match_qty=4, bid resting qty=6, ask_valid=0.
REQ-033 Buy 60x5 then sell 72x5 -> no match_signal, both valid; cancel_ask in IDLE -> ask_valid=0, sell_ready=1 next cycle.
REQ-034 Buy 50x3 and sell 50x3 in the same cycle -> match_signal high 2 cycles after acceptance edge, qty=3, both slots empty.
REQ-035 Buy 90x0 -> accepted, bid_valid stays 0, no CHECK; buy_valid held with bid occupied -> buy_ready=0, no acceptance.
REQ-036 reset_n pulsed low during CHECK of a crossing pair (82/78) -> match_signal never asserts, all outputs 0.
REQ-037 With ORDER_MATCHER_STATS_EN: 3 trades of qty 200 -> trade_count=3, total_volume=600; volume saturates at 65535 on overflow.
